// File: rtl/kbd_decode.sv
// PS/2 scancode decoder: pops the receiver FIFO, tracks held key / press count, drives 8 digits.
// Optional KBD_SHIFT_EN macro adds a shift flag (0x12 / 0x59) that upper-cases letters.
module kbd_decode (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic [7:0] o_seg0,
  output logic [7:0] o_seg1,
  output logic [7:0] o_seg2,
  output logic [7:0] o_seg3,
  output logic [7:0] o_seg4,
  output logic [7:0] o_seg5,
  output logic [7:0] o_seg6,
  output logic [7:0] o_seg7
);

`ifdef KBD_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StHeld, StBrk} state_e;

  // Digits 5..0; counter digits reset to the "0" glyph, the rest blank.
  localparam logic [5:0][7:0] SegReset = {8'h03, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  state_e          state_q, state_d, prev_q, prev_d;
  logic            arm_q, pop_q, pop_d;
  logic            shift_q, shift_d;
  logic [7:0]      cur_code_q, cur_code_d;
  logic [7:0]      count_q, count_d;
  logic [5:0][7:0] seg_q, seg_d;
  logic [7:0]      ascii;
  logic            is_shift_key;

  function automatic logic [7:0] seg_hex(input logic [3:0] v);
    logic [6:0] abcdefg;
    unique case (v)
      4'h0: abcdefg = 7'b1111110;
      4'h1: abcdefg = 7'b0110000;
      4'h2: abcdefg = 7'b1101101;
      4'h3: abcdefg = 7'b1111001;
      4'h4: abcdefg = 7'b0110011;
      4'h5: abcdefg = 7'b1011011;
      4'h6: abcdefg = 7'b1011111;
      4'h7: abcdefg = 7'b1110000;
      4'h8: abcdefg = 7'b1111111;
      4'h9: abcdefg = 7'b1111011;
      4'hA: abcdefg = 7'b1110111;
      4'hB: abcdefg = 7'b0011111;
      4'hC: abcdefg = 7'b1001110;
      4'hD: abcdefg = 7'b0111101;
      4'hE: abcdefg = 7'b1001111;
      4'hF: abcdefg = 7'b1000111;
    endcase
    return {~abcdefg, 1'b1};
  endfunction

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    case (code)
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      default: a = 8'h00;
    endcase
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

  assign is_shift_key  = ShiftEn && ((kb_data == 8'h12) || (kb_data == 8'h59));
  assign kb_nextdata_n = ~pop_q;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    shift_d    = shift_q;
    cur_code_d = cur_code_q;
    count_d    = count_q;
    // arm_q delays the first pop to the second edge after reset release.
    pop_d      = kb_ready & arm_q & ~pop_q;
    if (pop_q) begin
      if (kb_data == 8'hE0) begin
        state_d = state_q;
      end else if (kb_data == 8'hF0) begin
        if (state_q != StBrk) prev_d = state_q;
        state_d = StBrk;
      end else if (state_q == StBrk) begin
        if (is_shift_key) shift_d = 1'b0;
        state_d = (kb_data == cur_code_q) ? StIdle : prev_q;
      end else if (is_shift_key) begin
        shift_d = 1'b1;
      end else begin
        // Typematic repeats of the held key are not counted.
        if ((state_q == StIdle) || (kb_data != cur_code_q)) count_d = count_q + 8'd1;
        cur_code_d = kb_data;
        state_d    = StHeld;
      end
    end
  end

  always_comb begin
    ascii    = to_ascii(cur_code_q, shift_q);
    seg_d    = SegReset;
    seg_d[4] = seg_hex(count_q[3:0]);
    seg_d[5] = seg_hex(count_q[7:4]);
    if (state_q != StIdle) begin
      seg_d[0] = seg_hex(cur_code_q[3:0]);
      seg_d[1] = seg_hex(cur_code_q[7:4]);
      seg_d[2] = seg_hex(ascii[3:0]);
      seg_d[3] = seg_hex(ascii[7:4]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      prev_q     <= StIdle;
      arm_q      <= 1'b0;
      pop_q      <= 1'b0;
      shift_q    <= 1'b0;
      cur_code_q <= 8'h00;
      count_q    <= 8'h00;
      seg_q      <= SegReset;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      arm_q      <= 1'b1;
      pop_q      <= pop_d;
      shift_q    <= shift_d;
      cur_code_q <= cur_code_d;
      count_q    <= count_d;
      seg_q      <= seg_d;
    end
  end

  assign o_seg0 = seg_q[0];
  assign o_seg1 = seg_q[1];
  assign o_seg2 = seg_q[2];
  assign o_seg3 = seg_q[3];
  assign o_seg4 = seg_q[4];
  assign o_seg5 = seg_q[5];
  assign o_seg6 = 8'hFF;
  assign o_seg7 = 8'hFF;

endmodule

// File: tb/tb_kbd_decode.sv
// Directed bench for kbd_decode: a FIFO model feeds scancodes, digits checked against glyph constants.
module tb_kbd_decode;

  logic       clk;
  logic       resetn;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_nextdata_n;
  logic [7:0] o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;

  kbd_decode dut (
    .clk          (clk),
    .resetn       (resetn),
    .kb_data      (kb_data),
    .kb_ready     (kb_ready),
    .kb_nextdata_n(kb_nextdata_n),
    .o_seg0       (o_seg0),
    .o_seg1       (o_seg1),
    .o_seg2       (o_seg2),
    .o_seg3       (o_seg3),
    .o_seg4       (o_seg4),
    .o_seg5       (o_seg5),
    .o_seg6       (o_seg6),
    .o_seg7       (o_seg7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fifo [$];
  logic [7:0] seg_obs [8];
  logic [7:0] exp [8];
  bit         pop_pending;
  int         pops;
  int         b2b_viol;
  int         vectors;
  int         errors;

  always_comb begin
    seg_obs[0] = o_seg0; seg_obs[1] = o_seg1; seg_obs[2] = o_seg2; seg_obs[3] = o_seg3;
    seg_obs[4] = o_seg4; seg_obs[5] = o_seg5; seg_obs[6] = o_seg6; seg_obs[7] = o_seg7;
  end

  // One cycle: retire the byte popped last cycle, then note whether a pop is in flight now.
  task automatic tick();
    @(negedge clk);
    if (pop_pending) fifo.delete(0);
    if (!kb_nextdata_n) begin
      if (pop_pending) b2b_viol++;
      pops++;
      pop_pending = 1'b1;
    end else begin
      pop_pending = 1'b0;
    end
    kb_ready = (fifo.size() != 0);
    kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    kb_ready = 1'b1;
    kb_data  = fifo[0];
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || pop_pending) && n < budget) begin
      tick();
      n++;
    end
    if (fifo.size() != 0 || pop_pending) begin
      vectors++; errors++;
      $display("FAIL drain_timeout: %0d bytes left after %0d cycles", fifo.size(), budget);
    end
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    resetn      = 1'b0;
    fifo.delete();
    pop_pending = 1'b0;
    kb_ready    = 1'b0;
    kb_data     = 8'h00;
    pops        = 0;
    b2b_viol    = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL reset_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    vectors++;
    if (kb_nextdata_n !== 1'b1) begin
      errors++; $display("FAIL reset_nextdata: got %b want 1", kb_nextdata_n);
    end
  endtask

  task automatic test_make();
    apply_reset();
    push(8'h1C);
    tick();
    vectors++;
    if (kb_nextdata_n !== 1'b1) begin
      errors++; $display("FAIL first_edge_no_pop: got %b want 1", kb_nextdata_n);
    end
    tick();
    vectors++;
    if (kb_nextdata_n !== 1'b0) begin
      errors++; $display("FAIL second_edge_pop: got %b want 0", kb_nextdata_n);
    end
    tick();
    vectors++;
    if (o_seg0 !== 8'hFF) begin
      errors++; $display("FAIL latency_n1_seg0: got %h want ff", o_seg0);
    end
    tick();
    exp = '{8'h63, 8'h9F, 8'h9F, 8'h41, 8'h9F, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL make_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    vectors++;
    if (pops !== 1) begin
      errors++; $display("FAIL make_pops: got %0d want 1", pops);
    end
  endtask

  task automatic test_typematic();
    apply_reset();
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain(50);
    vectors++;
    if (pops !== 3) begin
      errors++; $display("FAIL typematic_pops: got %0d want 3", pops);
    end
    vectors++;
    if (b2b_viol !== 0) begin
      errors++; $display("FAIL pop_spacing: got %0d back-to-back pops want 0", b2b_viol);
    end
    exp = '{8'h63, 8'h9F, 8'h9F, 8'h41, 8'h9F, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL typematic_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_release();
    apply_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain(50);
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h9F, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL release_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_break_mismatch();
    apply_reset();
    push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
    drain(50);
    exp = '{8'h25, 8'h0D, 8'h25, 8'h41, 8'h25, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL brk_other_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    push(8'hF0); push(8'h32);
    drain(50);
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h25, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL brk_held_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k < 256; k++) begin
      push(8'h45); push(8'hF0); push(8'h45);
    end
    drain(2000);
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL wrap_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    push(8'hE0);
    drain(20);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL prefix_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    push(8'h75);
    drain(20);
    exp = '{8'h49, 8'h1F, 8'h03, 8'h03, 8'h9F, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL ext75_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    push(8'h45);
    drain(20);
    exp = '{8'h49, 8'h99, 8'h03, 8'h0D, 8'h25, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL digit0_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_shift();
    apply_reset();
    push(8'h12); push(8'h1C);
    drain(50);
`ifdef KBD_SHIFT_EN
    exp = '{8'h63, 8'h9F, 8'h9F, 8'h99, 8'h9F, 8'h03, 8'hFF, 8'hFF};
`else
    exp = '{8'h63, 8'h9F, 8'h9F, 8'h41, 8'h25, 8'h03, 8'hFF, 8'hFF};
`endif
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL shift_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_pop();
    int n;
    apply_reset();
    push(8'h45);
    drain(50);
    push(8'h1C);
    n = 0;
    while (kb_nextdata_n !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (kb_nextdata_n !== 1'b0) begin
      errors++; $display("FAIL midpop_wait: nextdata_n got %b want 0 within 10 cycles", kb_nextdata_n);
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (kb_nextdata_n !== 1'b1) begin
      errors++; $display("FAIL midpop_nextdata: got %b want 1", kb_nextdata_n);
    end
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (seg_obs[i] !== exp[i]) begin
        errors++; $display("FAIL midpop_seg%0d: got %h want %h", i, seg_obs[i], exp[i]);
      end
    end
    apply_reset();
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    pops        = 0;
    b2b_viol    = 0;
    pop_pending = 1'b0;
    kb_ready    = 1'b0;
    kb_data     = 8'h00;
    resetn      = 1'b0;
    test_reset();
    test_make();
    test_typematic();
    test_release();
    test_break_mismatch();
    test_wrap();
    test_shift();
    test_reset_mid_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/kbd_decode.md
KBD_DECODE -- requirements
Module: kbd_decode

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have kb_data, input, 8, scancode byte at the head of the PS/2 receiver FIFO.
REQ-004 SHALL have kb_ready, input, 1, high while the PS/2 FIFO is non-empty.
REQ-005 SHALL have kb_nextdata_n, output, 1, active-low pop strobe to the PS/2 FIFO.
REQ-006 SHALL have o_seg0..o_seg7, output, 8 each, active-low segments, bit7..bit1 = a..g, bit0 = dp.

Function
REQ-007 SHALL pop when kb_ready=1 and no pop occurred in the previous cycle: kb_nextdata_n=0 for exactly one cycle, kb_data sampled at the end of that cycle.
REQ-008 SHALL never pop in consecutive cycles; minimum pop spacing is 2 cycles.
REQ-009 SHALL run FSM IDLE / HELD / BRK: IDLE -> HELD on a make byte; HELD -> HELD on a make byte; any state -> BRK on 0xF0; BRK -> IDLE when the byte after 0xF0 equals the held code, otherwise BRK -> previous state.
REQ-010 SHALL discard 0xE0 prefix bytes with no state, counter or display change.
REQ-011 SHALL hold the last make code in an 8-bit register cur_code.
REQ-012 SHALL increment an 8-bit press counter on a make byte only when the state is IDLE or the code differs from cur_code; typematic repeats are not counted.
REQ-013 SHALL wrap the press counter 0xFF -> 0x00 silently.
REQ-014 SHALL map cur_code to ASCII via an internal table: 0-9 -> 0x30-0x39, letters -> 0x61-0x7A (e.g. 0x1C -> 0x61, 0x45 -> 0x30); unmapped codes -> 0x00.
REQ-015 SHALL drive o_seg1:o_seg0 = cur_code hex and o_seg3:o_seg2 = ASCII hex while HELD or BRK, and all-ones (blank) in IDLE.
REQ-016 SHALL drive o_seg5:o_seg4 = press counter hex at all times, and o_seg7, o_seg6 = 8'hFF constantly.
REQ-017 SHALL register all segment outputs; a byte popped in cycle N is reflected on the outputs from cycle N+2.
REQ-018 SHALL keep the dp bit (bit0) = 1 on all digits.

Reset
REQ-019 SHALL, while resetn=0, force state IDLE, cur_code=0x00, counter=0x00, kb_nextdata_n=1, o_seg0..o_seg3/o_seg6/o_seg7 = 8'hFF, and o_seg5:o_seg4 = the "0" glyph.
REQ-020 SHALL, on reset assertion in the middle of a pop cycle, deassert kb_nextdata_n immediately (asynchronously).
REQ-021 SHALL allow the first pop no earlier than the second clk edge after resetn rises.

Configuration
REQ-022 SHALL support macro KBD_SHIFT_EN: when defined, make/break of 0x12 and 0x59 sets/clears a shift flag without changing cur_code or the counter, and letters map to 0x41-0x5A while the flag is set.
REQ-023 SHALL, without KBD_SHIFT_EN, treat 0x12 and 0x59 as ordinary unmapped keys (ASCII 0x00, counted).

Verification
REQ-024 SHALL pass: reset, then FIFO presents 0x1C -> one pop pulse; seg1:seg0 show "1C", seg3:seg2 show "61", counter 0x01.
REQ-025 SHALL pass: 0x1C, 0x1C, 0x1C (typematic) -> three pops, each at least 2 cycles apart; counter stays 0x01.
REQ-026 SHALL pass: 0x1C, 0xF0, 0x1C -> state IDLE, seg0..seg3 = 8'hFF, counter 0x01.
REQ-027 SHALL pass: 256 press/release pairs of 0x45 -> counter wraps to 0x00; then 0xE0 0x75 -> counter 0x01 with no change caused by 0xE0.
REQ-028 SHALL pass: with KBD_SHIFT_EN defined, 0x12, 0x1C -> seg3:seg2 "41", counter 0x01; without the macro, the same input gives counter 0x02 and seg3:seg2 "61".
REQ-029 SHALL pass: resetn pulled low during the kb_nextdata_n=0 cycle -> kb_nextdata_n=1 within the same cycle and all outputs at their REQ-019 reset values.
